flow_lookup_responder: RTL
==========================

# flow_lookup_responder

Flow-table side of the `lu_req`/`lu_ack` lookup handshake. Accepts a composed match entry and packet length from the lookup-entry composer, acknowledges it, and performs a sequential masked search over a small register-based flow table. Delivers hit/miss, the winning index and its action word to the downstream action processor over a valid/ready interface. Maintains global hit and miss counters.

## Interface
Parameters:
- OPENFLOW_MATCH_SIZE, 256, width of the match entry and of each table entry and mask
- C_AXIS_LEN_DATA_WIDTH, 16, packet length width
- NUM_ENTRIES, 8, number of table rows (≥2)
- IDX_WIDTH, 3, index width (clog2(NUM_ENTRIES))
- ACTION_WIDTH, 32, action word width

Ports:
- asclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- lu_req  in  1  lookup request, held high by the initiator until it samples lu_ack
- lu_entry  in  OPENFLOW_MATCH_SIZE  match key, stable while lu_req is high
- lu_len  in  C_AXIS_LEN_DATA_WIDTH  packet length, stable while lu_req is high
- lu_ack  out  1  one-cycle acknowledge pulse
- tbl_wr_en  in  1  table write strobe
- tbl_wr_addr  in  IDX_WIDTH  row to write; values ≥ NUM_ENTRIES are ignored
- tbl_wr_valid  in  1  row valid bit
- tbl_wr_entry  in  OPENFLOW_MATCH_SIZE  row match value
- tbl_wr_mask  in  OPENFLOW_MATCH_SIZE  row care mask (1 = compare the bit)
- tbl_wr_action  in  ACTION_WIDTH  row action
- res_valid  out  1  result valid
- res_ready  in  1  downstream ready
- res_hit  out  1  1 = match found
- res_index  out  IDX_WIDTH  winning row (0 on miss)
- res_action  out  ACTION_WIDTH  winning row action (0 on miss)
- res_len  out  C_AXIS_LEN_DATA_WIDTH  latched lu_len
- hit_count  out  32  accepted hit results, wraps at 2^32
- miss_count  out  32  accepted miss results, wraps at 2^32

## Operation
- Reset: state IDLE; lu_ack, res_valid, res_hit, res_index, res_action, res_len, hit_count, miss_count = 0; all table valid bits = 0; req_seen_low = 1.
- req_seen_low: cleared on acceptance, set whenever lu_req is sampled 0. Prevents re-accepting a request still held high.
- IDLE: if lu_req=1 and req_seen_low=1, then latch lu_entry/lu_len into key/res_len, set idx=0, pulse lu_ack, and go to SEARCH.
- SEARCH: per cycle compare row idx. Match = valid[idx] and ((key ^ entry[idx]) & mask[idx]) == 0.
  - On match: res_hit=1, res_index=idx, res_action=action[idx], go to RESULT.
  - Else if idx = NUM_ENTRIES-1: res_hit=0, res_index=0, res_action=0, go to RESULT.
  - Else idx+1.
  - The lowest matching index wins. An all-zero mask on a valid row matches any key.
- RESULT: res_valid=1, outputs stable until res_valid&res_ready. On accept: res_valid=0, increment hit_count or miss_count, go to IDLE.
- lu_req is ignored outside IDLE. A new request is accepted no earlier than the cycle after RESULT completes.
- Table writes are accepted in any state. A row written in the same cycle it is compared is compared with its old contents; the new contents are visible from the next cycle.
- Reset mid-search or mid-result aborts the lookup, produces no result and no counter change, and clears the table.

## Timing
- Edge 0 samples lu_req=1 in IDLE. lu_ack is high for exactly cycle 1 and never for more than one cycle per request.
- Hit at row i: res_valid rises at cycle 2+i.
- Miss: res_valid rises at cycle 1+NUM_ENTRIES.
- res_valid with res_ready already high: the result is consumed in its first valid cycle, IDLE follows on the next cycle, and back-to-back acceptance is possible one cycle later if lu_req is high and req_seen_low=1.
- Counters update in the cycle after the accepting edge.

## Test plan
- Empty table after reset, request with lu_len=64: lu_ack pulses at cycle 1; res_valid at cycle 9 (NUM_ENTRIES=8) with res_hit=0, res_index=0, res_action=0, res_len=64; miss_count=1 after res_ready.
- Row 3 exact match (mask all-ones, action 0xA5A5_0003), request with the same key: res_valid at cycle 5, res_hit=1, res_index=3, res_action=0xA5A5_0003; hit_count=1.
- Rows 2 and 5 both match (row 5 mask all-zero): res_index=2; then invalidate row 2 and repeat: res_index=5.
- Initiator holds lu_req high for 3 cycles after ack, res_ready=1: exactly one lu_ack and one result; no second acceptance until lu_req has been low.
- res_ready low for 10 cycles during RESULT: res_* stable throughout, counters unchanged until the accept edge; lu_req asserted meanwhile is not acked until after IDLE.
- aresetn low during SEARCH at idx=4: lu_ack=0, res_valid=0, counters 0, table invalid; the next request is a miss.

Source files
------------

// File: rtl/flow_lookup_responder.sv
// Flow-table responder: acknowledges a lookup request, searches the table one row per cycle
// and returns hit/miss, winning index and action over a valid/ready result interface.
module flow_lookup_responder #(
  parameter int unsigned OPENFLOW_MATCH_SIZE   = 256,
  parameter int unsigned C_AXIS_LEN_DATA_WIDTH = 16,
  parameter int unsigned NUM_ENTRIES           = 8,
  parameter int unsigned IDX_WIDTH             = 3,
  parameter int unsigned ACTION_WIDTH          = 32
) (
  input  logic                             asclk,
  input  logic                             aresetn,
  input  logic                             lu_req,
  input  logic [OPENFLOW_MATCH_SIZE-1:0]   lu_entry,
  input  logic [C_AXIS_LEN_DATA_WIDTH-1:0] lu_len,
  output logic                             lu_ack,
  input  logic                             tbl_wr_en,
  input  logic [IDX_WIDTH-1:0]             tbl_wr_addr,
  input  logic                             tbl_wr_valid,
  input  logic [OPENFLOW_MATCH_SIZE-1:0]   tbl_wr_entry,
  input  logic [OPENFLOW_MATCH_SIZE-1:0]   tbl_wr_mask,
  input  logic [ACTION_WIDTH-1:0]          tbl_wr_action,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic                             res_hit,
  output logic [IDX_WIDTH-1:0]             res_index,
  output logic [ACTION_WIDTH-1:0]          res_action,
  output logic [C_AXIS_LEN_DATA_WIDTH-1:0] res_len,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
);

  typedef enum logic [1:0] {StIdle, StSearch, StResult} state_e;

  state_e                             state_q, state_d;
  logic [IDX_WIDTH-1:0]               idx_q, idx_d;
  logic [OPENFLOW_MATCH_SIZE-1:0]     key_q, key_d;
  logic                               req_seen_low_q, req_seen_low_d;
  logic                               lu_ack_q, lu_ack_d;
  logic                               res_hit_q, res_hit_d;
  logic [IDX_WIDTH-1:0]               res_index_q, res_index_d;
  logic [ACTION_WIDTH-1:0]            res_action_q, res_action_d;
  logic [C_AXIS_LEN_DATA_WIDTH-1:0]   res_len_q, res_len_d;
  logic [31:0]                        hit_count_q, hit_count_d;
  logic [31:0]                        miss_count_q, miss_count_d;

  logic [NUM_ENTRIES-1:0]             tbl_valid_q;
  logic [OPENFLOW_MATCH_SIZE-1:0]     tbl_entry_q  [NUM_ENTRIES];
  logic [OPENFLOW_MATCH_SIZE-1:0]     tbl_mask_q   [NUM_ENTRIES];
  logic [ACTION_WIDTH-1:0]            tbl_action_q [NUM_ENTRIES];

  logic wr_addr_ok;
  logic row_match;
  logic idx_last;

  // Out-of-range addresses only exist when the table is not a power of two.
  if (NUM_ENTRIES == (2 ** IDX_WIDTH)) begin : g_full_range
    assign wr_addr_ok = 1'b1;
  end else begin : g_partial_range
    assign wr_addr_ok = (32'(tbl_wr_addr) < NUM_ENTRIES);
  end

  // Table writes land at the clock edge, so a row compared this cycle sees its old contents.
  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      tbl_valid_q <= '0;
    end else if (tbl_wr_en && wr_addr_ok) begin
      tbl_valid_q[tbl_wr_addr] <= tbl_wr_valid;
    end
  end

  always_ff @(posedge asclk) begin
    if (tbl_wr_en && wr_addr_ok) begin
      tbl_entry_q[tbl_wr_addr]  <= tbl_wr_entry;
      tbl_mask_q[tbl_wr_addr]   <= tbl_wr_mask;
      tbl_action_q[tbl_wr_addr] <= tbl_wr_action;
    end
  end

  assign row_match = tbl_valid_q[idx_q] &&
                     (((key_q ^ tbl_entry_q[idx_q]) & tbl_mask_q[idx_q]) == '0);
  assign idx_last  = (idx_q == IDX_WIDTH'(NUM_ENTRIES - 1));

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    key_d          = key_q;
    lu_ack_d       = 1'b0;
    res_hit_d      = res_hit_q;
    res_index_d    = res_index_q;
    res_action_d   = res_action_q;
    res_len_d      = res_len_q;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    req_seen_low_d = req_seen_low_q | ~lu_req;

    unique case (state_q)
      StIdle: begin
        if (lu_req && req_seen_low_q) begin
          key_d          = lu_entry;
          res_len_d      = lu_len;
          idx_d          = '0;
          lu_ack_d       = 1'b1;
          req_seen_low_d = 1'b0;
          state_d        = StSearch;
        end
      end
      StSearch: begin
        if (row_match) begin
          res_hit_d    = 1'b1;
          res_index_d  = idx_q;
          res_action_d = tbl_action_q[idx_q];
          state_d      = StResult;
        end else if (idx_last) begin
          res_hit_d    = 1'b0;
          res_index_d  = '0;
          res_action_d = '0;
          state_d      = StResult;
        end else begin
          idx_d = idx_q + IDX_WIDTH'(1);
        end
      end
      StResult: begin
        if (res_ready) begin
          if (res_hit_q) hit_count_d = hit_count_q + 32'd1;
          else           miss_count_d = miss_count_q + 32'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      key_q          <= '0;
      req_seen_low_q <= 1'b1;
      lu_ack_q       <= 1'b0;
      res_hit_q      <= 1'b0;
      res_index_q    <= '0;
      res_action_q   <= '0;
      res_len_q      <= '0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      key_q          <= key_d;
      req_seen_low_q <= req_seen_low_d;
      lu_ack_q       <= lu_ack_d;
      res_hit_q      <= res_hit_d;
      res_index_q    <= res_index_d;
      res_action_q   <= res_action_d;
      res_len_q      <= res_len_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign lu_ack     = lu_ack_q;
  assign res_valid  = (state_q == StResult);
  assign res_hit    = res_hit_q;
  assign res_index  = res_index_q;
  assign res_action = res_action_q;
  assign res_len    = res_len_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
